// File: rtl/tmc4671_pkg.sv
// Shared types and constants for the multi-channel TMC4671 Avalon/SPI bridge.
package tmc4671_pkg;

   localparam int FRAME_BITS    = 40;
   localparam int REG_ADDR_BITS = 7;
   localparam int DATA_BITS     = 32;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, GAP} state_t;

   // clk cycles per SCK half-period, never below one
   function automatic int spi_div(input int clk_hz, input int spi_hz);
      int d;
      d = clk_hz / (2 * spi_hz);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/tmc4671_spi_frame.sv
// One 40-bit SPI mode-3 datagram: chip-select setup, 40 shifted bits, chip-select hold.
module tmc4671_spi_frame
   import tmc4671_pkg::*;
#(
   parameter int DIV = 25
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] frame,
   input  logic                  miso,
   output logic                  sck,
   output logic                  mosi,
   output logic                  cs_active,
   output logic [DATA_BITS-1:0]  rx_data,
   output logic                  done
);

   // state | meaning
   // IDLE  | waiting for start
   // SETUP | chip select low, SCK high, first bit on MOSI, DIV cycles
   // SHIFT | 40 bits of DIV low + DIV high SCK cycles
   // HOLD  | SCK high, chip select still low, DIV cycles

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);

   state_t                  phase, phase_nxt;
   logic [DIV_W-1:0]        div_cnt;
   logic [5:0]              bit_cnt;
   logic [FRAME_BITS-2:0]   tx;
   logic                    div_tc;
   logic                    last_bit;

   assign div_tc   = (div_cnt == '0);
   assign last_bit = (bit_cnt == 6'(FRAME_BITS - 1));

   always_ff @(posedge clk) begin
      if (reset) phase <= IDLE;
      else       phase <= phase_nxt;
   end

   always_comb begin
      phase_nxt = phase;
      case (phase)
         IDLE:    if (start) phase_nxt = SETUP;
         SETUP:   if (div_tc) phase_nxt = SHIFT;
         SHIFT:   if (div_tc && sck && last_bit) phase_nxt = HOLD;
         HOLD:    if (div_tc) phase_nxt = IDLE;
         default: phase_nxt = IDLE;
      endcase
   end

   always_comb begin
      done = (phase == HOLD) && div_tc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt   <= '0;
         bit_cnt   <= '0;
         tx        <= '0;
         rx_data   <= '0;
         sck       <= 1'b1;
         mosi      <= 1'b0;
         cs_active <= 1'b0;
      end else begin
         case (phase)
            IDLE: begin
               if (start) begin
                  div_cnt   <= DIV_LOAD;
                  bit_cnt   <= '0;
                  tx        <= frame[FRAME_BITS-2:0];
                  mosi      <= frame[FRAME_BITS-1];
                  sck       <= 1'b1;
                  cs_active <= 1'b1;
               end
            end
            SETUP: begin
               if (div_tc) begin
                  div_cnt <= DIV_LOAD;
                  sck     <= 1'b0;
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            SHIFT: begin
               if (div_tc) begin
                  div_cnt <= DIV_LOAD;
                  if (!sck) begin
                     sck     <= 1'b1;
                     rx_data <= {rx_data[DATA_BITS-2:0], miso};
                  end else if (!last_bit) begin
                     // falling edge: present the next frame bit
                     sck     <= 1'b0;
                     bit_cnt <= bit_cnt + 6'd1;
                     mosi    <= tx[FRAME_BITS-2];
                     tx      <= {tx[FRAME_BITS-3:0], 1'b0};
                  end
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            HOLD: begin
               if (div_tc) begin
                  cs_active <= 1'b0;
                  mosi      <= 1'b0;
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/tmc4671_avalon_multi.sv
// Avalon-MM slave bridging register accesses to NUM_CHANNELS TMC4671 chips on a shared SPI bus.
// Optional local status window: define TMC4671_STATUS_WINDOW_EN.
module tmc4671_avalon_multi
   import tmc4671_pkg::*;
#(
   parameter int CLOCK_FREQ_HZ = 50_000_000,
   parameter int SPI_FREQ_HZ   = 1_000_000,
   parameter int NUM_CHANNELS  = 4,
   parameter int GAP_CYCLES    = 50,
   parameter int CH_BITS       = $clog2(NUM_CHANNELS + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [REG_ADDR_BITS+CH_BITS-1:0] address,
   input  logic                             write,
   input  logic [DATA_BITS-1:0]             writedata,
   input  logic                             read,
   output logic [DATA_BITS-1:0]             readdata,
   output logic                             waitrequest,
   output logic [NUM_CHANNELS-1:0]          nSCS,
   output logic                             SCK,
   output logic                             MOSI,
   input  logic [NUM_CHANNELS-1:0]          MISO
);

   // state | meaning
   // IDLE  | waiting for a command
   // SETUP | SPI frame in flight (engine runs setup/shift/hold)
   // DONE  | one cycle, waitrequest low, readdata valid
   // GAP   | GAP_CYCLES cycles with all chip selects high

   localparam int DIV   = spi_div(CLOCK_FREQ_HZ, SPI_FREQ_HZ);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t                   state_q, state_nxt;
   logic [CH_BITS-1:0]       addr_ch, ch_q;
   logic [REG_ADDR_BITS-1:0] addr_reg;
   logic                     cmd, accept, ch_valid, start, wr_q;
   logic [GAP_W-1:0]         gap_cnt;
   logic                     gap_tc;
   logic [NUM_CHANNELS-1:0]  cs_onehot;
   logic [FRAME_BITS-1:0]    frame;
   logic [DATA_BITS-1:0]     eng_rx, local_rdata;
   logic                     eng_cs, eng_done, miso_sel;

   assign cmd      = read | write;
   assign addr_ch  = address[REG_ADDR_BITS +: CH_BITS];
   assign addr_reg = address[REG_ADDR_BITS-1:0];
   assign ch_valid = (addr_ch < CH_BITS'(NUM_CHANNELS));
   assign accept   = (state_q == IDLE) && cmd;
   assign start    = accept && ch_valid;
   assign gap_tc   = (gap_cnt == '0);
   assign frame    = {write, addr_reg, (write ? writedata : {DATA_BITS{1'b0}})};
   assign miso_sel = |(MISO & cs_onehot);

   tmc4671_spi_frame #(.DIV(DIV)) u_frame (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .frame     (frame),
      .miso      (miso_sel),
      .sck       (SCK),
      .mosi      (MOSI),
      .cs_active (eng_cs),
      .rx_data   (eng_rx),
      .done      (eng_done)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (cmd) state_nxt = start ? SETUP : DONE;
         SETUP:   if (eng_done) state_nxt = DONE;
         DONE:    state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
         GAP:     if (gap_tc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cs_onehot   = NUM_CHANNELS'(1) << ch_q;
      waitrequest = cmd & (state_q != DONE);
      nSCS        = ~(cs_onehot & {NUM_CHANNELS{eng_cs}});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ch_q     <= '0;
         wr_q     <= 1'b0;
         readdata <= '0;
         gap_cnt  <= '0;
      end else begin
         if (accept) begin
            ch_q <= addr_ch;
            wr_q <= write;
         end
         if ((state_q == SETUP) && eng_done)
            readdata <= wr_q ? '0 : eng_rx;
         else if (accept && !start)
            readdata <= local_rdata;
         if (state_q == DONE)
            gap_cnt <= GAP_LOAD;
         else if ((state_q == GAP) && !gap_tc)
            gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

`ifdef TMC4671_STATUS_WINDOW_EN
   logic [DATA_BITS-1:0] frame_count;
   logic [7:0]           last_ch;
   logic                 win_sel;

   assign win_sel = (addr_ch == CH_BITS'(NUM_CHANNELS));

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count <= '0;
         last_ch     <= '0;
      end else begin
         if ((state_q == SETUP) && eng_done) begin
            frame_count <= frame_count + 32'd1;
            last_ch     <= 8'(ch_q);
         end
         if (accept && write && win_sel && (addr_reg == '0))
            frame_count <= '0;
      end
   end

   always_comb begin
      local_rdata = '0;
      if (win_sel && !write) begin
         case (addr_reg)
            7'd0:    local_rdata = frame_count;
            7'd1:    local_rdata = {24'h0, last_ch};
            default: local_rdata = '0;
         endcase
      end
   end
`else
   assign local_rdata = '0;
`endif

endmodule

// File: tb/tb_tmc4671_avalon_multi.sv
// Directed self-checking bench for tmc4671_avalon_multi (default parameters, DIV = 25).
module tb_tmc4671_avalon_multi;

   localparam int FRAME_LAT = 2051;   // 1 + 82*25
   localparam int GAP       = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  address;
   logic        write, read;
   logic [31:0] writedata, readdata;
   logic        waitrequest;
   logic [3:0]  nSCS;
   logic        SCK, MOSI;
   logic [3:0]  MISO;

   int checks = 0;
   int passed = 0;

   logic [39:0] miso_word = '0;
   int          miso_idx  = 40;
   int          miso_ch   = 0;
   logic        miso_bit;

   tmc4671_avalon_multi dut (
      .clk(clk), .reset(reset), .address(address), .write(write),
      .writedata(writedata), .read(read), .readdata(readdata),
      .waitrequest(waitrequest), .nSCS(nSCS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   // chip model: shifts out its next response bit on every SCK falling edge
   always @(negedge SCK) if (nSCS !== 4'hF && miso_idx > 0) miso_idx = miso_idx - 1;

   always_comb begin
      miso_bit = (miso_idx >= 0 && miso_idx < 40) ? miso_word[miso_idx] : 1'b0;
      MISO = '0;
      for (int i = 0; i < 4; i++) MISO[i] = (i == miso_ch) ? miso_bit : ~miso_bit;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // drives one command at the current negedge and collects observations until waitrequest drops
   task automatic run_cmd(input logic wr, input logic [2:0] ch, input logic [6:0] ra,
                          input logic [31:0] wd, input logic [39:0] resp,
                          output int lat, output logic [39:0] bits, output int nbits,
                          output int low_at, output logic cs_bad, output logic [31:0] rd);
      logic [3:0] exp_cs;
      logic       sck_prev;
      exp_cs    = ~(4'b0001 << ch);
      miso_word = resp;
      miso_idx  = 40;
      miso_ch   = int'(ch);
      address   = {ch, ra};
      write     = wr;
      read      = ~wr;
      writedata = wd;
      lat = -1; bits = '0; nbits = 0; low_at = -1; cs_bad = 1'b0; rd = 'x;
      sck_prev = SCK;
      for (int n = 1; n <= 5000 && lat < 0; n++) begin
         @(negedge clk);
         if (nSCS !== 4'hF) begin
            if (low_at < 0) low_at = n;
            if (nSCS !== exp_cs) cs_bad = 1'b1;
            if (!sck_prev && SCK) begin
               bits  = {bits[38:0], MOSI};
               nbits = nbits + 1;
            end
         end
         sck_prev = SCK;
         if (!waitrequest) begin
            lat = n;
            rd  = readdata;
         end
      end
      write = 1'b0;
      read  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
      idle(3);
      reset = 1'b0;
      idle(1);
      checks++; if (nSCS !== 4'hF) $display("FAIL reset_nscs: got %b want 1111", nSCS); else passed++;
      checks++; if (SCK !== 1'b1) $display("FAIL reset_sck: got %b want 1", SCK); else passed++;
      checks++; if (MOSI !== 1'b0) $display("FAIL reset_mosi: got %b want 0", MOSI); else passed++;
      checks++; if (readdata !== 32'h0) $display("FAIL reset_readdata: got %h want 0", readdata); else passed++;
      checks++; if (waitrequest !== 1'b0) $display("FAIL reset_waitreq: got %b want 0", waitrequest); else passed++;
   endtask

   task automatic test_write_frame();
      int lat, nb, lo; logic [39:0] b; logic bad; logic [31:0] rd;
      run_cmd(1'b1, 3'd2, 7'h1C, 32'h0001_0001, 40'hA5_DEADBEEF, lat, b, nb, lo, bad, rd);
      checks++; if (lat != FRAME_LAT) $display("FAIL wr_latency: got %0d want %0d", lat, FRAME_LAT); else passed++;
      checks++; if (b !== 40'h9C_0001_0001) $display("FAIL wr_mosi: got %h want 9c00010001", b); else passed++;
      checks++; if (nb != 40) $display("FAIL wr_nbits: got %0d want 40", nb); else passed++;
      checks++; if (bad !== 1'b0 || lo != 1) $display("FAIL wr_nscs: bad=%b first_low=%0d want bad=0 first_low=1", bad, lo); else passed++;
      checks++; if (rd !== 32'h0) $display("FAIL wr_readdata: got %h want 0", rd); else passed++;
      checks++; if (SCK !== 1'b1) $display("FAIL wr_sck_idle: got %b want 1", SCK); else passed++;
   endtask

   task automatic test_read_frame();
      int lat, nb, lo; logic [39:0] b; logic bad; logic [31:0] rd;
      idle(GAP + 5);
      run_cmd(1'b0, 3'd0, 7'h00, 32'hFFFF_FFFF, 40'h5A_3467_1000, lat, b, nb, lo, bad, rd);
      checks++; if (lat != FRAME_LAT) $display("FAIL rd_latency: got %0d want %0d", lat, FRAME_LAT); else passed++;
      checks++; if (rd !== 32'h3467_1000) $display("FAIL rd_data: got %h want 34671000", rd); else passed++;
      checks++; if (b !== 40'h0 || nb != 40) $display("FAIL rd_mosi: got %h/%0d want 0000000000/40", b, nb); else passed++;
      checks++; if (bad !== 1'b0) $display("FAIL rd_nscs: got bad=%b want 0", bad); else passed++;
      idle(10);
      checks++; if (readdata !== 32'h3467_1000) $display("FAIL rd_hold: got %h want 34671000", readdata); else passed++;
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, nb1, nb2, lo1, lo2; logic [39:0] b1, b2; logic bad1, bad2; logic [31:0] rd1, rd2;
      idle(GAP + 5);
      run_cmd(1'b1, 3'd1, 7'h21, 32'hCAFE_F00D, 40'h0, lat1, b1, nb1, lo1, bad1, rd1);
      run_cmd(1'b0, 3'd3, 7'h7F, 32'h0, 40'h00_89AB_CDEF, lat2, b2, nb2, lo2, bad2, rd2);
      checks++; if (b1 !== 40'hA1_CAFE_F00D) $display("FAIL b2b_mosi1: got %h want a1cafef00d", b1); else passed++;
      checks++; if (lat2 != FRAME_LAT + GAP + 1) $display("FAIL b2b_latency2: got %0d want %0d", lat2, FRAME_LAT + GAP + 1); else passed++;
      checks++; if (lo2 < GAP || lo2 != GAP + 2) $display("FAIL b2b_gap: nscs first low at %0d want %0d", lo2, GAP + 2); else passed++;
      checks++; if (b2 !== 40'h7F_0000_0000 || bad2 !== 1'b0) $display("FAIL b2b_frame2: got %h bad=%b want 7f00000000 bad=0", b2, bad2); else passed++;
      checks++; if (rd2 !== 32'h89AB_CDEF) $display("FAIL b2b_rdata: got %h want 89abcdef", rd2); else passed++;
   endtask

   task automatic test_reset_mid_frame();
      int lat, nb, lo, cnt; logic [39:0] b; logic bad; logic [31:0] rd; logic prev;
      idle(GAP + 5);
      miso_word = 40'h0; miso_idx = 40; miso_ch = 2;
      address = {3'd2, 7'h10}; read = 1'b1; write = 1'b0;
      cnt = 0; prev = SCK;
      for (int n = 0; n < 3000 && cnt < 20; n++) begin
         @(negedge clk);
         if (!prev && SCK && nSCS !== 4'hF) cnt++;
         prev = SCK;
      end
      checks++; if (cnt != 20 || nSCS !== 4'b1011) $display("FAIL rst_mid_prep: bits=%0d nscs=%b want 20/1011", cnt, nSCS); else passed++;
      reset = 1'b1; read = 1'b0;
      @(negedge clk);
      checks++; if (nSCS !== 4'hF || SCK !== 1'b1 || MOSI !== 1'b0)
         $display("FAIL rst_mid_outputs: nscs=%b sck=%b mosi=%b want 1111/1/0", nSCS, SCK, MOSI); else passed++;
      reset = 1'b0;
      @(negedge clk);
      run_cmd(1'b0, 3'd1, 7'h05, 32'h0, 40'hFF_1234_5678, lat, b, nb, lo, bad, rd);
      checks++; if (lat != FRAME_LAT || rd !== 32'h1234_5678)
         $display("FAIL rst_mid_next_read: lat=%0d data=%h want %0d/12345678", lat, rd, FRAME_LAT); else passed++;
      checks++; if (b !== 40'h05_0000_0000 || bad !== 1'b0) $display("FAIL rst_mid_next_mosi: got %h bad=%b want 0500000000", b, bad); else passed++;
   endtask

   task automatic test_out_of_range();
      int lat, nb, lo; logic [39:0] b; logic bad; logic [31:0] rd;
      idle(GAP + 5);
`ifndef TMC4671_STATUS_WINDOW_EN
      run_cmd(1'b0, 3'd4, 7'h01, 32'h0, 40'hFF_FFFF_FFFF, lat, b, nb, lo, bad, rd);
      checks++; if (lat != 1 || rd !== 32'h0 || lo != -1)
         $display("FAIL oor_ch4: lat=%0d data=%h first_low=%0d want 1/0/-1", lat, rd, lo); else passed++;
      idle(GAP + 5);
`endif
      run_cmd(1'b0, 3'd5, 7'h03, 32'h0, 40'hFF_FFFF_FFFF, lat, b, nb, lo, bad, rd);
      checks++; if (lat != 1 || rd !== 32'h0 || lo != -1)
         $display("FAIL oor_ch5_read: lat=%0d data=%h first_low=%0d want 1/0/-1", lat, rd, lo); else passed++;
      idle(GAP + 5);
      run_cmd(1'b1, 3'd5, 7'h03, 32'h1234_5678, 40'h0, lat, b, nb, lo, bad, rd);
      checks++; if (lat != 1 || lo != -1) $display("FAIL oor_ch5_write: lat=%0d first_low=%0d want 1/-1", lat, lo); else passed++;
   endtask

`ifdef TMC4671_STATUS_WINDOW_EN
   task automatic test_status_window();
      int lat, nb, lo; logic [39:0] b; logic bad; logic [31:0] rd;
      idle(GAP + 5);
      run_cmd(1'b1, 3'd4, 7'h00, 32'h0, 40'h0, lat, b, nb, lo, bad, rd);
      idle(GAP + 5);
      run_cmd(1'b1, 3'd3, 7'h01, 32'h0000_0001, 40'h0, lat, b, nb, lo, bad, rd);
      checks++; if (bad !== 1'b0 || lo != 1) $display("FAIL win_frame_ch3: bad=%b first_low=%0d want 0/1", bad, lo); else passed++;
      idle(GAP + 5);
      run_cmd(1'b0, 3'd1, 7'h02, 32'h0, 40'h0, lat, b, nb, lo, bad, rd);
      idle(GAP + 5);
      run_cmd(1'b1, 3'd2, 7'h03, 32'h0000_0003, 40'h0, lat, b, nb, lo, bad, rd);
      idle(GAP + 5);
      run_cmd(1'b0, 3'd4, 7'h00, 32'h0, 40'h0, lat, b, nb, lo, bad, rd);
      checks++; if (lat != 1 || rd !== 32'd3 || lo != -1) $display("FAIL win_count: lat=%0d data=%h want 1/3", lat, rd); else passed++;
      idle(GAP + 5);
      run_cmd(1'b0, 3'd4, 7'h01, 32'h0, 40'h0, lat, b, nb, lo, bad, rd);
      checks++; if (rd !== 32'd2) $display("FAIL win_last_ch: got %h want 2", rd); else passed++;
      idle(GAP + 5);
      run_cmd(1'b1, 3'd4, 7'h00, 32'hFFFF_FFFF, 40'h0, lat, b, nb, lo, bad, rd);
      idle(GAP + 5);
      run_cmd(1'b0, 3'd4, 7'h00, 32'h0, 40'h0, lat, b, nb, lo, bad, rd);
      checks++; if (rd !== 32'd0) $display("FAIL win_clear: got %h want 0", rd); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_write_frame();
      test_read_frame();
      test_back_to_back();
      test_reset_mid_frame();
      test_out_of_range();
`ifdef TMC4671_STATUS_WINDOW_EN
      test_status_window();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/tmc4671_avalon_multi.md
Name: tmc4671_avalon_multi

Overview:
Avalon-MM slave that bridges host register accesses to NUM_CHANNELS TMC4671 motor-controller chips over one shared SPI bus (SCK/MOSI shared, per-chip nSCS and MISO). Upper address bits select the chip and the lower 7 bits carry the TMC4671 register address. Each access is one 40-bit SPI mode-3 datagram, and read data returns within the same datagram. It sits between the Qsys interconnect and the motor-board connectors, and replaces the single-chip bridge.

Parameters:
CLOCK_FREQ_HZ, 50_000_000, system clock frequency
SPI_FREQ_HZ, 1_000_000, SCK frequency; DIV = max(1, CLOCK_FREQ_HZ/(2*SPI_FREQ_HZ)) clk cycles per SCK half-period
NUM_CHANNELS, 4, number of TMC4671 chips (1..8)
GAP_CYCLES, 50, minimum nSCS-high clk cycles between frames
CH_BITS, $clog2(NUM_CHANNELS+1), channel-select field width (derived, do not override)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
address  in  7+CH_BITS  [6:0] register address, [7+:CH_BITS] channel
write  in  1  Avalon write
writedata  in  32  write payload
read  in  1  Avalon read
readdata  out  32  read result, valid in the cycle waitrequest is low for a read
waitrequest  out  1  Avalon stall
nSCS  out  NUM_CHANNELS  per-chip chip select, active low
SCK  out  1  SPI clock, idles high
MOSI  out  1  SPI data out
MISO  in  NUM_CHANNELS  per-chip SPI data in

Behaviour:
- Reset: state IDLE, nSCS all 1, SCK 1, MOSI 0, readdata 0, shift/bit/divider counters 0. Reset mid-frame aborts immediately; the aborted command is not completed.
- waitrequest = (read|write) & (state != DONE), combinational. It is low for exactly one cycle per command.
- Accept: in IDLE with read|write high, latch channel, addr, write bit and data. If both read and write are high, write wins. Go to SETUP next cycle.
- Frame = {wr_bit, addr[6:0], data[31:0]}, MSB first. wr_bit=1 for a write. For a read the data field is sent as 0.
- SETUP: nSCS[ch]=0, SCK=1, MOSI=frame[39]. Hold DIV cycles, then SHIFT.
- SHIFT: 40 bits, each = DIV cycles SCK low + DIV cycles SCK high.
  - MOSI updates on the SCK falling edge. MISO[ch] is sampled on the SCK rising edge.
  - The last 32 sampled bits form rx_data.
- HOLD: SCK=1, nSCS low for DIV cycles, then nSCS[ch]=1. Go to DONE.
- DONE: one cycle. readdata=rx_data for a read, 0 for a write. Then GAP.
- GAP: GAP_CYCLES cycles with all nSCS high, then IDLE. Commands arriving in GAP/SETUP/SHIFT/HOLD stall (waitrequest=1).
- Latency: accept cycle A. DONE occurs at A+1+82*DIV. The next accept occurs no earlier than DONE+GAP_CYCLES+1.
- Out-of-range channel (ch >= NUM_CHANNELS) without the optional feature: no SPI activity, DONE on the cycle after accept, readdata 0.
- Only one nSCS bit is ever low at a time. readdata holds its value until the next DONE.

Optional Feature:
TMC4671_STATUS_WINDOW_EN
- With it: channel field == NUM_CHANNELS selects a local window. No SPI activity; DONE on the cycle after accept.
  - Read reg 0: 32-bit count of completed SPI frames (wraps).
  - Read reg 1: {24'b0, last channel (8 bits)}.
  - Other regs read 0. Writes to reg 0 clear the count; other writes are ignored.
- Without it: window decode absent; the out-of-range rule applies.

Decomposition:
- Package tmc4671_pkg:
  - FRAME_BITS=40, REG_ADDR_BITS=7, DATA_BITS=32
  - state enum {IDLE, SETUP, SHIFT, HOLD, DONE, GAP}
  - function spi_div(clk_hz, spi_hz)
- Sub-module tmc4671_spi_frame: SETUP/SHIFT/HOLD engine.
  - Inputs: start, 40-bit frame, MISO bit.
  - Outputs: SCK, MOSI, cs_active, rx_data, done pulse.
- The top level owns the Avalon FSM, channel decode, nSCS fan-out and GAP.

Test Plan:
1. Write ch2 addr 0x1C data 0x00010001, DIV=25: nSCS=4'b1011 only; MOSI stream 0x9C_00010001; waitrequest low exactly at A+2051; SCK idles high.
2. Read ch0 addr 0x00, MISO[0] model returns 0x34671000: readdata=0x34671000 in the DONE cycle; MOSI stream 0x00_00000000.
3. Back-to-back write then read held on the bus: second accept not before DONE+GAP_CYCLES+1; nSCS high for ≥50 cycles between frames.
4. Assert reset at bit 20 of a frame: next cycle nSCS=all 1, SCK=1, MOSI=0. A following read completes normally.
5. Channel 5 with NUM_CHANNELS=4, macro off: no nSCS activity; waitrequest low at A+1; readdata=0.
6. Macro on: three frames, then read window reg 0 → 3; reg 1 → last channel; write reg 0, then read → 0.
